// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the main-memory arbiter.
//   arb_state_e       - arbiter FSM state encoding
//   DEF_BLOCK_WORDS   - default 16-bit words per cache block
//   DEF_MEM_LATENCY   - default read latency of the pipelined memory
//   BLOCK_OFFSET_BITS - byte-offset bits inside one block
//   block_base()      - block-aligned base address of a byte address
package mem_arbiter_pkg;

  localparam int unsigned DEF_BLOCK_WORDS   = 8;
  localparam int unsigned DEF_MEM_LATENCY   = 4;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_FILL_D = 3'd2,
    ST_FILL_I = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & ~16'((1 << BLOCK_OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/fill_sequencer.sv
// fill_sequencer: address generation and return tracking for one block fill.
//   clk, rst   - clock, synchronous active-high reset
//   start      - pulse in the IDLE cycle a fill is accepted; latches req_addr
//   req_addr   - miss address (any byte inside the block)
//   active     - high while the arbiter is in a fill state
//   mem_valid  - read data valid from memory
//   issue      - a read should be issued this cycle at fill_addr
//   fill_addr  - base + 2*issue_cnt
//   rcv_strobe - mem_valid accepted as a word of this fill
//   word_idx   - index of the word carried by the accepted return
//   last_word  - accepted return is the final word of the block
module fill_sequencer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  localparam int unsigned CW = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   req_addr,
  input  logic          active,
  input  logic          mem_valid,
  output logic          issue,
  output logic [15:0]   fill_addr,
  output logic          rcv_strobe,
  output logic [CW-1:0] word_idx,
  output logic          last_word
);

  localparam int unsigned CNTW      = CW + 1;
  localparam int unsigned BLANK_INT = (MEM_LATENCY < BLOCK_WORDS) ? MEM_LATENCY : BLOCK_WORDS;
  localparam logic [CW:0]   ISSUE_END = CNTW'(BLOCK_WORDS);
  localparam logic [CW:0]   BLANK     = CNTW'(BLANK_INT);
  localparam logic [CW-1:0] LAST_IDX  = CW'(BLOCK_WORDS - 1);

  logic [15:0]   base_q;
  logic [CW:0]   issue_cnt_q;  // saturates at BLOCK_WORDS; doubles as fill-cycle age
  logic [CW-1:0] rcv_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else if (start) begin
      base_q      <= block_base(req_addr);
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else if (active) begin
      if (issue)      issue_cnt_q <= issue_cnt_q + 1'b1;
      if (rcv_strobe) rcv_cnt_q   <= rcv_cnt_q + 1'b1;
    end
  end

  assign issue     = active && (issue_cnt_q < ISSUE_END);
  assign fill_addr = base_q + 16'({issue_cnt_q[CW-1:0], 1'b0});

  // No read of this fill can return in its first MEM_LATENCY cycles, so
  // returns there belong to reads orphaned by a reset and are dropped.
  assign rcv_strobe = active && mem_valid && (issue_cnt_q >= BLANK);
  assign word_idx   = rcv_cnt_q;
  assign last_word  = rcv_strobe && (rcv_cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences I-cache fills, D-cache fills and D-cache
// write-through stores onto one pipelined main memory, one at a time.
//   clk, rst                - clock, synchronous active-high reset
//   i_miss, i_addr          - I-cache miss request and fetch address
//   d_miss, d_wr            - D-cache miss request, store in MEM stage
//   d_addr, d_wdata         - data address and store data
//   mem_en/mem_wr/mem_addr/mem_wdata - memory command port
//   mem_data, mem_valid     - memory read return
//   fill_data, word_num     - word and index written into the cache
//   i_write_data/i_write_tag, d_write_data/d_write_tag - cache array strobes
//   i_stall, d_stall        - hold IF / hold whole pipeline
//   busy                    - arbiter not idle
//   dbg_state               - current FSM state
//
// Request protocol: i_miss, d_miss and d_wr are level requests held by the
// requester until served. A fill is accepted in the IDLE cycle it wins
// priority and is complete when its tag strobe fires; a store is accepted in
// the IDLE cycle it wins and completes in the following WRITE cycle. The
// matching stall line is the "not ready" indication back to the pipeline.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  word_num,
  output logic        i_write_data,
  output logic        i_write_tag,
  output logic        d_write_data,
  output logic        d_write_tag,
  output logic        i_stall,
  output logic        d_stall,
  output logic        busy,
  output arb_state_e  dbg_state
);

  arb_state_e  state_q, state_d;
  logic        owner_d_q;  // 1: D-cache owns the current fill
  logic        start;
  logic        fill_active;
  logic        issue;
  logic [15:0] fill_addr;
  logic        rcv_strobe;
  logic [2:0]  word_idx;
  logic        last_word;

  assign start       = (state_q == ST_IDLE) && (d_miss || (!d_wr && i_miss));
  assign fill_active = (state_q == ST_FILL_D) || (state_q == ST_FILL_I);

  fill_sequencer #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_addr   (d_miss ? d_addr : i_addr),
    .active     (fill_active),
    .mem_valid  (mem_valid),
    .issue      (issue),
    .fill_addr  (fill_addr),
    .rcv_strobe (rcv_strobe),
    .word_idx   (word_idx),
    .last_word  (last_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) owner_d_q <= d_miss;
    end
  end

  // Next state: D fill beats store beats I fill; no preemption once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_miss)      state_d = ST_FILL_D;
        else if (d_wr)   state_d = ST_WRITE;
        else if (i_miss) state_d = ST_FILL_I;
      end
      ST_WRITE:             state_d = ST_IDLE;
      ST_FILL_D, ST_FILL_I: if (last_word) state_d = ST_DONE;
      ST_DONE:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    word_num     = 3'd0;
    i_write_data = 1'b0;
    i_write_tag  = 1'b0;
    d_write_data = 1'b0;
    d_write_tag  = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem_en   = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = d_addr & 16'hFFFE;
      end
      ST_FILL_D, ST_FILL_I: begin
        mem_en = issue;
        if (issue) mem_addr = fill_addr;
        if (rcv_strobe) word_num = word_idx;
        i_write_data = rcv_strobe && !owner_d_q;
        d_write_data = rcv_strobe &&  owner_d_q;
        i_write_tag  = last_word  && !owner_d_q;
        d_write_tag  = last_word  &&  owner_d_q;
      end
      default: ;
    endcase
  end

  assign mem_wdata = d_wdata;
  assign fill_data = mem_data;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  assign d_stall = d_miss || ((state_q == ST_IDLE) && d_wr) || (state_q == ST_FILL_D);
  assign i_stall = i_miss || (state_q == ST_FILL_I);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a fixed-latency
// pipelined memory model and a scoreboard of expected reads, fills and writes.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_data, fill_data;
  logic [2:0]  word_num;
  logic        i_write_data, i_write_tag, d_write_data, d_write_tag;
  logic        i_stall, d_stall, busy;
  arb_state_e  dbg_state;

  mem_arbiter #(.MEM_LATENCY(LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid),
    .fill_data(fill_data), .word_num(word_num),
    .i_write_data(i_write_data), .i_write_tag(i_write_tag),
    .d_write_data(d_write_data), .d_write_tag(d_write_tag),
    .i_stall(i_stall), .d_stall(d_stall), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- memory model (ignores reset, like the real part) -----
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];
  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end

  always @(posedge clk) begin
    pipe_v[0] <= mem_en && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign mem_valid = pipe_v[LAT-1];
  assign mem_data  = pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : 16'h0000;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_rd_q[$];
  logic [22:0] exp_fill_q[$];  // {i_wd, d_wd, i_tag, d_tag, word_num, data}
  logic [31:0] exp_wr_q[$];    // {addr, data}
  int wr_cnt = 0;

  task automatic push_fill(input bit is_i, input logic [15:0] addr,
                           input int n_rd, input int n_fill);
    logic [15:0] base;
    logic [15:0] a;
    logic [2:0]  w3;
    base = addr & 16'hFFF0;
    for (int k = 0; k < n_rd; k++) exp_rd_q.push_back(base + 16'(2 * k));
    for (int w = 0; w < n_fill; w++) begin
      a  = base + 16'(2 * w);
      w3 = 3'(w);
      exp_fill_q.push_back({is_i, !is_i, is_i && (w == 7), !is_i && (w == 7), w3, mem_word(a)});
    end
  endtask

  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      else check("rd_addr", {16'h0, mem_addr}, {16'h0, exp_rd_q.pop_front()});
    end
    if (mem_en && mem_wr) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) check("wr_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
    end
    if (i_write_data || d_write_data || i_write_tag || d_write_tag) begin
      if (exp_fill_q.size() == 0)
        check("fill_unexpected", {9'h0, i_write_data, d_write_data, i_write_tag, d_write_tag,
                                   word_num, fill_data}, 32'hFFFF_FFFF);
      else
        check("fill_word", {9'h0, i_write_data, d_write_data, i_write_tag, d_write_tag,
                            word_num, fill_data}, {9'h0, exp_fill_q.pop_front()});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watches a fill from the current cycle until its tag strobe (bounded).
  task automatic wait_fill(input bit is_i, input logic [15:0] base,
                           output int first_rd, output int first_wd,
                           output int tag_at, output int other_low);
    first_rd = -1; first_wd = -1; tag_at = -1; other_low = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (first_rd < 0 && mem_en && !mem_wr && mem_addr == base) first_rd = cyc;
      if (first_wd < 0 && (is_i ? i_write_data : d_write_data)) first_wd = cyc;
      if ((is_i ? d_stall : i_stall) == 1'b0) other_low++;
      if (is_i ? i_write_tag : d_write_tag) begin
        tag_at = cyc;
        break;
      end
    end
  endtask

  function automatic logic [27:0] ctrl_vec();
    return {mem_en, mem_wr, mem_addr, word_num, i_write_data, i_write_tag,
            d_write_data, d_write_tag, i_stall, d_stall, busy};
  endfunction

  // ---------------- stimulus ----------------
  int t0, frd, fwd, tg, olow, w0;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {4'h0, ctrl_vec()}, 32'h0);
    check("rst_data", {mem_wdata, fill_data}, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst = 1'b0;
    step();

    // 1: I-miss at 0x0016
    i_addr = 16'h0016; i_miss = 1'b1; t0 = cyc;
    push_fill(1'b1, 16'h0016, 8, 8);
    wait_fill(1'b1, 16'h0010, frd, fwd, tg, olow);
    check("i_first_rd_cyc", 32'(frd - t0), 32'd1);
    check("i_first_wd_cyc", 32'(fwd - t0), 32'd5);
    check("i_tag_cyc", 32'(tg - t0), 32'd12);
    step(); i_miss = 1'b0;
    @(negedge clk);
    check("i_done_stall_en_busy", {29'h0, i_stall, mem_en, busy}, 32'h1);
    step();
    @(negedge clk);
    check("i_after_done_busy", {31'h0, busy}, 32'h0);

    // 2: store hit
    step();
    w0 = wr_cnt;
    d_wr = 1'b1; d_addr = 16'h2002; d_wdata = 16'hBEEF;
    exp_wr_q.push_back({16'h2002, 16'hBEEF});
    @(negedge clk);
    check("st_c0_stall_en", {30'h0, d_stall, mem_en}, 32'h2);
    step();
    @(negedge clk);
    check("st_c1_stall_en_wr", {29'h0, d_stall, mem_en, mem_wr}, 32'h3);
    step(); d_wr = 1'b0;
    @(negedge clk);
    check("st_c2_stall", {31'h0, d_stall}, 32'h0);
    step();
    check("st_write_count", 32'(wr_cnt - w0), 32'd1);

    // 3: d_miss and i_miss together
    d_miss = 1'b1; d_addr = 16'h400A; i_miss = 1'b1; i_addr = 16'h0100; t0 = cyc;
    push_fill(1'b0, 16'h400A, 8, 8);
    push_fill(1'b1, 16'h0100, 8, 8);
    wait_fill(1'b0, 16'h4000, frd, fwd, tg, olow);
    check("both_d_tag_cyc", 32'(tg - t0), 32'd12);
    check("both_i_stall_low_cycles", 32'(olow), 32'd0);
    step(); d_miss = 1'b0;
    @(negedge clk);
    check("both_done_stalls", {30'h0, d_stall, i_stall}, 32'h1);
    wait_fill(1'b1, 16'h0100, frd, fwd, tg, olow);
    check("both_i_first_rd_cyc", 32'(frd - t0), 32'd15);
    check("both_i_tag_cyc", 32'(tg - t0), 32'd26);
    step(); i_miss = 1'b0;
    step();

    // 4: store miss at 0x3008
    d_miss = 1'b1; d_wr = 1'b1; d_addr = 16'h3008; d_wdata = 16'h1234; t0 = cyc;
    push_fill(1'b0, 16'h3008, 8, 8);
    exp_wr_q.push_back({16'h3008, 16'h1234});
    wait_fill(1'b0, 16'h3000, frd, fwd, tg, olow);
    check("sm_tag_cyc", 32'(tg - t0), 32'd12);
    step(); d_miss = 1'b0;
    @(negedge clk);
    check("sm_done_stall", {31'h0, d_stall}, 32'h0);
    step();
    @(negedge clk);
    check("sm_idle_stall_en", {30'h0, d_stall, mem_en}, 32'h2);
    step();
    @(negedge clk);
    check("sm_write_cycle", {29'h0, mem_en, mem_wr, d_stall}, 32'h6);
    step(); d_wr = 1'b0;
    step();

    // 5: reset during cycle 6 of an I fill, then a fresh fill
    i_miss = 1'b1; i_addr = 16'h0504;
    push_fill(1'b1, 16'h0504, 6, 2);
    repeat (6) step();
    rst = 1'b1; i_miss = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", {4'h0, ctrl_vec()}, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    i_miss = 1'b1; i_addr = 16'h0606; t0 = cyc;
    push_fill(1'b1, 16'h0606, 8, 8);
    wait_fill(1'b1, 16'h0600, frd, fwd, tg, olow);
    check("rerun_first_wd_cyc", 32'(fwd - t0), 32'd5);
    check("rerun_tag_cyc", 32'(tg - t0), 32'd12);
    step(); i_miss = 1'b0;
    step();

    // 6: top-of-memory block
    d_miss = 1'b1; d_addr = 16'hFFF4; t0 = cyc;
    push_fill(1'b0, 16'hFFF4, 8, 8);
    wait_fill(1'b0, 16'hFFF0, frd, fwd, tg, olow);
    check("top_first_rd_cyc", 32'(frd - t0), 32'd1);
    check("top_tag_cyc", 32'(tg - t0), 32'd12);
    step(); d_miss = 1'b0;
    repeat (10) step();

    check("rd_q_left", 32'(exp_rd_q.size()), 32'd0);
    check("fill_q_left", 32'(exp_fill_q.size()), 32'd0);
    check("wr_q_left", 32'(exp_wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
